// File: rtl/fifo_seu_pkg.sv
// Shared types and record layout helpers for the FIFO SEU statistics collector.
package fifo_seu_pkg;

  localparam int LANE_IDX_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SNAP,
    ST_SEND,
    ST_DONE
  } state_e;

  function automatic int pc_width(input int k);
    return $clog2(k + 1);
  endfunction

  function automatic int rec_width(input int w, input int m);
    return LANE_IDX_W + 3 * w + m + 1;
  endfunction

  // Record layout from LSB: sat, err flags, pg_warn count, dbit count, sbit count, lane index.
  function automatic int err_lsb();
    return 1;
  endfunction

  function automatic int pgw_lsb(input int m);
    return 1 + m;
  endfunction

  function automatic int dbit_lsb(input int w, input int m);
    return 1 + m + w;
  endfunction

  function automatic int sbit_lsb(input int w, input int m);
    return 1 + m + 2 * w;
  endfunction

  function automatic int idx_lsb(input int w, input int m);
    return 1 + m + 3 * w;
  endfunction

endpackage

// File: rtl/fifo_seu_collector_if.sv
// Record stream from the SEU collector to the readout logic.
interface fifo_seu_collector_if #(
  parameter int RW = 60
);
  logic          busy_o;
  logic          rec_valid_o;
  logic          rec_ready_i;
  logic [RW-1:0] rec_data_o;
  logic          rec_last_o;

  modport master (
    output busy_o,
    output rec_valid_o,
    input  rec_ready_i,
    output rec_data_o,
    output rec_last_o
  );

  modport slave (
    input  busy_o,
    input  rec_valid_o,
    output rec_ready_i,
    input  rec_data_o,
    input  rec_last_o
  );
endinterface

// File: rtl/fifo_seu_lane_cnt.sv
// One lane of live saturating SEU counters plus the shadow copy frozen on a snapshot.
module fifo_seu_lane_cnt
  import fifo_seu_pkg::*;
#(
  parameter int K = 48,
  parameter int M = 3,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [K-1:0] sbiterr,
  input  logic [K-1:0] dbiterr,
  input  logic         pg_warn,
  input  logic [M-1:0] err,
  input  logic         snap,
  output logic [W-1:0] sh_sbit,
  output logic [W-1:0] sh_dbit,
  output logic [W-1:0] sh_pgw,
  output logic [M-1:0] sh_err,
  output logic         sh_sat
);

  localparam int PCW = pc_width(K);
  localparam int SW  = W + 1;

  logic [W-1:0]   sbit_cnt, dbit_cnt, pgw_cnt;
  logic [W-1:0]   sbit_nxt, dbit_nxt, pgw_nxt;
  logic [M-1:0]   err_flags, err_nxt;
  logic           sat, sat_nxt, pg_prev;
  logic [PCW-1:0] pc_s, pc_d;
  logic [SW-1:0]  sum_s, sum_d, sum_p;

  // NOTE: every always_comb output gets a default first, so no path leaves a latch.
  always_comb begin
    pc_s = '0;
    pc_d = '0;
    for (int b = 0; b < K; b++) begin
      pc_s = pc_s + PCW'(sbiterr[b]);
      pc_d = pc_d + PCW'(dbiterr[b]);
    end
    // The extra top bit of each sum is the overflow that pins the counter at all-ones.
    sum_s    = {1'b0, sbit_cnt} + SW'(pc_s);
    sum_d    = {1'b0, dbit_cnt} + SW'(pc_d);
    sum_p    = {1'b0, pgw_cnt} + SW'(pg_warn & ~pg_prev);
    sbit_nxt = sum_s[W] ? '1 : sum_s[W-1:0];
    dbit_nxt = sum_d[W] ? '1 : sum_d[W-1:0];
    pgw_nxt  = sum_p[W] ? '1 : sum_p[W-1:0];
    err_nxt  = err_flags | err;
    sat_nxt  = sat | sum_s[W] | sum_d[W] | sum_p[W];
  end

  // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
  // NOTE: shadow registers are reset as well; they drive the record bus directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbit_cnt  <= '0;
      dbit_cnt  <= '0;
      pgw_cnt   <= '0;
      err_flags <= '0;
      sat       <= 1'b0;
      pg_prev   <= 1'b0;
      sh_sbit   <= '0;
      sh_dbit   <= '0;
      sh_pgw    <= '0;
      sh_err    <= '0;
      sh_sat    <= 1'b0;
    end else begin
      pg_prev <= pg_warn;
      if (snap) begin
        // This cycle's events land in the shadow; the live set restarts empty.
        sh_sbit   <= sbit_nxt;
        sh_dbit   <= dbit_nxt;
        sh_pgw    <= pgw_nxt;
        sh_err    <= err_nxt;
        sh_sat    <= sat_nxt;
        sbit_cnt  <= '0;
        dbit_cnt  <= '0;
        pgw_cnt   <= '0;
        err_flags <= '0;
        sat       <= 1'b0;
      end else begin
        sbit_cnt  <= sbit_nxt;
        dbit_cnt  <= dbit_nxt;
        pgw_cnt   <= pgw_nxt;
        err_flags <= err_nxt;
        sat       <= sat_nxt;
      end
    end
  end

endmodule

// File: rtl/fifo_seu_collector.sv
// Per-lane SEU statistics collector: L lane counters, snapshot FSM and record streamer.
module fifo_seu_collector
  import fifo_seu_pkg::*;
#(
  parameter int K = 48,
  parameter int M = 3,
  parameter int L = 8,
  parameter int W = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [L*K-1:0]      sbiterr_i,
  input  logic [L*K-1:0]      dbiterr_i,
  input  logic [L-1:0]        pg_warn_i,
  input  logic [L*M-1:0]      err_i,
  input  logic                snap_i,
  fifo_seu_collector_if.master rec
);

  localparam int RW       = rec_width(W, M);
  localparam int IDX_LSB  = idx_lsb(W, M);
  localparam int SBIT_LSB = sbit_lsb(W, M);
  localparam int DBIT_LSB = dbit_lsb(W, M);
  localparam int PGW_LSB  = pgw_lsb(M);
  localparam int ERR_LSB  = err_lsb();
  localparam logic [LANE_IDX_W-1:0] LAST_IDX = LANE_IDX_W'(L - 1);

  logic [W-1:0]            sh_sbit [L];
  logic [W-1:0]            sh_dbit [L];
  logic [W-1:0]            sh_pgw  [L];
  logic [M-1:0]            sh_err  [L];
  logic [L-1:0]            sh_sat;
  state_e                  state;
  logic [LANE_IDX_W-1:0]   idx;
  logic [RW-1:0]           rec_word;

  for (genvar i = 0; i < L; i++) begin : g_lane
    fifo_seu_lane_cnt #(
      .K (K),
      .M (M),
      .W (W)
    ) u_lane (
      .clk     (clk_i),
      .rst_n   (rst_n_i),
      .sbiterr (sbiterr_i[i*K +: K]),
      .dbiterr (dbiterr_i[i*K +: K]),
      .pg_warn (pg_warn_i[i]),
      .err     (err_i[i*M +: M]),
      .snap    (state == ST_SNAP),
      .sh_sbit (sh_sbit[i]),
      .sh_dbit (sh_dbit[i]),
      .sh_pgw  (sh_pgw[i]),
      .sh_err  (sh_err[i]),
      .sh_sat  (sh_sat[i])
    );
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state           <= ST_IDLE;
      idx             <= '0;
      rec.busy_o      <= 1'b0;
      rec.rec_valid_o <= 1'b0;
      rec.rec_last_o  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (snap_i) begin
            state      <= ST_SNAP;
            rec.busy_o <= 1'b1;
          end
        end
        ST_SNAP: begin
          idx             <= '0;
          rec.rec_valid_o <= 1'b1;
          rec.rec_last_o  <= (L == 1);
          state           <= ST_SEND;
        end
        ST_SEND: begin
          if (rec.rec_ready_i) begin
            if (idx == LAST_IDX) begin
              rec.rec_valid_o <= 1'b0;
              rec.rec_last_o  <= 1'b0;
              state           <= ST_DONE;
            end else begin
              idx            <= idx + 1'b1;
              rec.rec_last_o <= ((idx + 1'b1) == LAST_IDX);
            end
          end
        end
        ST_DONE: begin
          rec.busy_o <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The bus is zero whenever no record is offered, so a reset clears it at once.
  always_comb begin
    rec_word = '0;
    if (rec.rec_valid_o) begin
      rec_word[IDX_LSB +: LANE_IDX_W] = idx;
      for (int i = 0; i < L; i++) begin
        if (idx == LANE_IDX_W'(i)) begin
          rec_word[SBIT_LSB +: W] = sh_sbit[i];
          rec_word[DBIT_LSB +: W] = sh_dbit[i];
          rec_word[PGW_LSB +: W]  = sh_pgw[i];
          rec_word[ERR_LSB +: M]  = sh_err[i];
          rec_word[0]             = sh_sat[i];
        end
      end
    end
  end

  assign rec.rec_data_o = rec_word;

endmodule

// File: tb/tb_fifo_seu_collector.sv
// Directed, table-driven bench for fifo_seu_collector with K=48, M=3, L=8, W=16.
module tb_fifo_seu_collector;

  localparam int K  = 48;
  localparam int M  = 3;
  localparam int L  = 8;
  localparam int W  = 16;
  localparam int RW = 60;

  typedef struct {
    int          lane;
    logic [47:0] sb;
    logic [47:0] db;
    int          cycles;
    logic [15:0] exp_sb;
    logic [15:0] exp_db;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [L*K-1:0] sbiterr = '0;
  logic [L*K-1:0] dbiterr = '0;
  logic [L-1:0]   pg_warn = '0;
  logic [L*M-1:0] err = '0;
  logic           snap = 1'b0;

  logic [15:0] exp_sb  [L];
  logic [15:0] exp_db  [L];
  logic [15:0] exp_pg  [L];
  logic [2:0]  exp_err [L];
  logic        exp_sat [L];

  int pass_cnt  = 0;
  int total_cnt = 0;

  fifo_seu_collector_if #(.RW(RW)) rec_if ();

  fifo_seu_collector #(
    .K (K),
    .M (M),
    .L (L),
    .W (W)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .sbiterr_i (sbiterr),
    .dbiterr_i (dbiterr),
    .pg_warn_i (pg_warn),
    .err_i     (err),
    .snap_i    (snap),
    .rec       (rec_if.master)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < L; i++) begin
      exp_sb[i] = '0; exp_db[i] = '0; exp_pg[i] = '0; exp_err[i] = '0; exp_sat[i] = 1'b0;
    end
  endtask

  function automatic logic [RW-1:0] exp_rec(input int i);
    return {8'(i), exp_sb[i], exp_db[i], exp_pg[i], exp_err[i], exp_sat[i]};
  endfunction

  // Snap request, with optional sbiterr events on lane ev_lane: ev_pre in the request
  // cycle, ev_snap in the SNAP cycle. Returns at the first negedge the record should be valid.
  task automatic do_snap(input int ev_lane, input logic [47:0] ev_pre, input logic [47:0] ev_snap);
    @(negedge clk);
    snap = 1'b1;
    sbiterr[ev_lane*K +: K] = ev_pre;
    @(negedge clk);
    snap = 1'b0;
    sbiterr[ev_lane*K +: K] = ev_snap;
    check("snap_valid_low", rec_if.rec_valid_o, 1'b0);
    check("snap_busy", rec_if.busy_o, 1'b1);
    @(negedge clk);
    sbiterr = '0;
    check("first_valid_latency", rec_if.rec_valid_o, 1'b1);
  endtask

  // Drain the record stream; bp selects 1-in-3 ready, snap_at pulses snap_i at that cycle.
  task automatic collect(input bit bp, input int snap_at);
    int             n = 0;
    int             cyc = 0;
    bit             hold = 0;
    logic [RW-1:0]  held_data = '0;
    logic           held_last = 1'b0;
    while (n < L && cyc < 200) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      if (hold) begin
        check("stall_valid", rec_if.rec_valid_o, 1'b1);
        check("stall_data", rec_if.rec_data_o, held_data);
        check("stall_last", rec_if.rec_last_o, held_last);
      end
      snap = (cyc == snap_at);
      rec_if.rec_ready_i = bp ? (cyc % 3 == 0) : 1'b1;
      if (!rec_if.rec_valid_o) begin
        check("stream_valid", rec_if.rec_valid_o, 1'b1);
        hold = 0;
      end else if (rec_if.rec_ready_i) begin
        check($sformatf("rec%0d_data", n), rec_if.rec_data_o, exp_rec(n));
        check($sformatf("rec%0d_last", n), rec_if.rec_last_o, (n == L - 1));
        n++;
        hold = 0;
      end else begin
        hold = 1;
        held_data = rec_if.rec_data_o;
        held_last = rec_if.rec_last_o;
      end
    end
    snap = 1'b0;
    check("record_count", 64'(n), 64'(L));
    @(negedge clk);
    check("done_valid", rec_if.rec_valid_o, 1'b0);
    check("done_busy", rec_if.busy_o, 1'b1);
    @(negedge clk);
    check("idle_busy", rec_if.busy_o, 1'b0);
    repeat (4) @(negedge clk);
    check("no_queued_snap_valid", rec_if.rec_valid_o, 1'b0);
    check("no_queued_snap_busy", rec_if.busy_o, 1'b0);
  endtask

  initial begin
    vec_t vecs [4];
    vecs[0] = '{3, 48'h5,              48'h0,              10, 16'd20, 16'd0};
    vecs[1] = '{0, 48'h0,              48'h8000_0000_0000,  4, 16'd0,  16'd4};
    vecs[2] = '{7, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF,  2, 16'd96, 16'd96};
    vecs[3] = '{6, 48'h8000_0000_0001, 48'hF,               3, 16'd6,  16'd12};

    rec_if.rec_ready_i = 1'b1;
    clear_exp();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", rec_if.rec_valid_o, 1'b0);
    check("rst_busy", rec_if.busy_o, 1'b0);
    check("rst_last", rec_if.rec_last_o, 1'b0);
    check("rst_data", rec_if.rec_data_o, '0);
    rst_n = 1'b1;

    // Empty interval
    do_snap(0, '0, '0);
    collect(0, 0);

    // Table: popcount accumulation per lane
    for (int v = 0; v < 4; v++) begin
      clear_exp();
      exp_sb[vecs[v].lane] = vecs[v].exp_sb;
      exp_db[vecs[v].lane] = vecs[v].exp_db;
      @(negedge clk);
      sbiterr[vecs[v].lane*K +: K] = vecs[v].sb;
      dbiterr[vecs[v].lane*K +: K] = vecs[v].db;
      repeat (vecs[v].cycles) @(negedge clk);
      sbiterr = '0;
      dbiterr = '0;
      do_snap(0, '0, '0);
      collect(0, 0);
    end

    // pg_warn edge counting and sticky err flags
    clear_exp();
    exp_pg[5]  = 16'd2;
    exp_err[2] = 3'b010;
    @(negedge clk);
    pg_warn[5] = 1'b1;
    err[2*M +: M] = 3'b010;
    @(negedge clk);
    err = '0;
    repeat (99) @(negedge clk);
    pg_warn[5] = 1'b0;
    @(negedge clk);
    pg_warn[5] = 1'b1;
    @(negedge clk);
    pg_warn[5] = 1'b0;
    do_snap(0, '0, '0);
    collect(0, 0);

    // Saturation, then a fresh interval restarts at zero with sat clear
    clear_exp();
    exp_sb[1]  = 16'hFFFF;
    exp_sat[1] = 1'b1;
    @(negedge clk);
    sbiterr[1*K +: K] = '1;
    repeat (1400) @(negedge clk);
    sbiterr = '0;
    do_snap(0, '0, '0);
    collect(0, 0);
    clear_exp();
    do_snap(0, '0, '0);
    collect(0, 0);

    // Events in the request and SNAP cycles, backpressure, snap during SEND
    clear_exp();
    exp_sb[2] = 16'd3;
    do_snap(2, 48'h1, 48'h6);
    collect(1, 5);
    clear_exp();
    do_snap(0, '0, '0);
    collect(0, 0);

    // Reset in the middle of the stream
    do_snap(0, '0, '0);
    rec_if.rec_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("pre_reset_idx", 64'(rec_if.rec_data_o[RW-1 -: 8]), 64'(k));
      sbiterr[1*K +: K] = (k == 0) ? 48'hF : 48'h0;
      @(negedge clk);
    end
    check("pre_reset_idx4", 64'(rec_if.rec_data_o[RW-1 -: 8]), 64'd4);
    rst_n = 1'b0;
    #1;
    check("abort_valid", rec_if.rec_valid_o, 1'b0);
    check("abort_data", rec_if.rec_data_o, '0);
    check("abort_last", rec_if.rec_last_o, 1'b0);
    check("abort_busy", rec_if.busy_o, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_exp();
    do_snap(0, '0, '0);
    collect(0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
